quadrature_generator: RTL and testbench

- Synthesizable quadrature encoder emulator: drives A/B phase outputs and a Z index output from a commanded target position.
- Produces the waveforms that the quadrature decoder block consumes. Used for closed-loop bench testing of the decoder and for driving downstream stepper/servo interfaces.
- Steps one quadrature state per programmable period toward the target, always by the shortest modular path.

---
 rtl/quadrature_generator.sv | 121 ++++++++++++
 tb/tb_quadrature_generator.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/quadrature_generator.sv
// Quadrature encoder emulator: walks a gray-coded A/B phase toward a commanded
// target one state per programmable period, with an index pulse on z.
module quadrature_generator #(
  parameter int WIDTH     = 16,
  parameter int DIV_WIDTH = 16,
  parameter int CPR_LOG2  = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [WIDTH-1:0]     target,
  input  logic                 target_load,
  input  logic [DIV_WIDTH-1:0] period,
  output logic                 a,
  output logic                 b,
  output logic                 z,
  output logic [WIDTH-1:0]     pos,
  output logic                 busy
);

  localparam logic [1:0] S0 = 2'd0;
  localparam logic [1:0] S1 = 2'd1;
  localparam logic [1:0] S2 = 2'd2;
  localparam logic [1:0] S3 = 2'd3;

  localparam logic [DIV_WIDTH-1:0] DIV_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]     POS_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]     tgt;
  logic [WIDTH-1:0]     diff;
  logic [WIDTH-1:0]     pos_nxt;
  logic [DIV_WIDTH-1:0] div;
  logic [DIV_WIDTH-1:0] div_nxt;
  logic [DIV_WIDTH-1:0] per_eff;
  logic [DIV_WIDTH-1:0] per_m1;
  logic [1:0]           phase;
  logic [1:0]           phase_nxt;
  logic                 at_tgt;
  logic                 fwd;
  logic                 step;

  function automatic logic [1:0] phase_fwd(input logic [1:0] s);
    case (s)
      S0:      phase_fwd = S1;
      S1:      phase_fwd = S2;
      S2:      phase_fwd = S3;
      default: phase_fwd = S0;
    endcase
  endfunction

  function automatic logic [1:0] phase_bwd(input logic [1:0] s);
    case (s)
      S0:      phase_bwd = S3;
      S3:      phase_bwd = S2;
      S2:      phase_bwd = S1;
      default: phase_bwd = S0;
    endcase
  endfunction

  // Gray mapping guarantees exactly one of a/b toggles per state change.
  function automatic logic [1:0] phase_ab(input logic [1:0] s);
    case (s)
      S0:      phase_ab = 2'b00;
      S1:      phase_ab = 2'b01;
      S2:      phase_ab = 2'b11;
      default: phase_ab = 2'b10;
    endcase
  endfunction

  always_comb begin
    per_eff = (period == '0) ? DIV_ONE : period;
    per_m1  = per_eff - DIV_ONE;
    diff    = tgt - pos;
    at_tgt  = (diff == '0);
    // Half-range difference (MSB set) resolves backward, giving the shortest modular path.
    fwd     = ~diff[WIDTH-1];
    step    = enable & ~at_tgt & (div >= per_m1);
  end

  always_comb begin
    div_nxt   = div + DIV_ONE;
    pos_nxt   = pos;
    phase_nxt = phase;
    if (!enable || at_tgt) begin
      div_nxt = '0;
    end else if (step) begin
      div_nxt = '0;
      if (fwd) begin
        pos_nxt   = pos + POS_ONE;
        phase_nxt = phase_fwd(phase);
      end else begin
        pos_nxt   = pos - POS_ONE;
        phase_nxt = phase_bwd(phase);
      end
    end
  end

  // Busy compares against the pre-load tgt so a simultaneous load takes effect next cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos    <= '0;
      tgt    <= '0;
      div    <= '0;
      phase  <= S0;
      {a, b} <= 2'b00;
      z      <= 1'b1;
      busy   <= 1'b0;
    end else begin
      pos    <= pos_nxt;
      div    <= div_nxt;
      phase  <= phase_nxt;
      {a, b} <= phase_ab(phase_nxt);
      z      <= (pos_nxt[CPR_LOG2-1:0] == '0);
      busy   <= (pos_nxt != tgt);
      if (target_load) begin
        tgt <= target;
      end
    end
  end

endmodule

// File: tb/tb_quadrature_generator.sv
// Bench for quadrature_generator: a position/elapsed-time model checked every
// cycle against two instances (default index period and CPR_LOG2=2).
module tb_quadrature_generator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] target;
  logic        target_load;
  logic [15:0] period;
  logic        a, b, z, busy;
  logic [15:0] pos;
  logic        a2, b2, z2, busy2;
  logic [15:0] pos2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  quadrature_generator dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .target(target),
    .target_load(target_load), .period(period),
    .a(a), .b(b), .z(z), .pos(pos), .busy(busy)
  );

  quadrature_generator #(.WIDTH(16), .DIV_WIDTH(16), .CPR_LOG2(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .target(target),
    .target_load(target_load), .period(period),
    .a(a2), .b(b2), .z(z2), .pos(pos2), .busy(busy2)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: position, target and cycles elapsed since the last step.
  logic [15:0] m_pos, m_tgt, m_old, m_d;
  int          m_el, m_p;
  logic        m_busy;
  bit          m_valid = 0;

  function automatic logic [1:0] gray(input logic [15:0] p);
    case (p % 4)
      0:       gray = 2'b00;
      1:       gray = 2'b01;
      2:       gray = 2'b11;
      default: gray = 2'b10;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pos = 0; m_tgt = 0; m_el = 0; m_busy = 0; m_valid = 1;
    end else begin
      m_p   = (period == 0) ? 1 : int'(period);
      m_old = m_tgt;
      if (enable && m_pos != m_tgt) begin
        m_el = m_el + 1;
        if (m_el >= m_p) begin
          m_el = 0;
          m_d  = m_tgt - m_pos;
          if (m_d < 16'h8000) m_pos = m_pos + 16'd1;
          else                m_pos = m_pos - 16'd1;
        end
      end else begin
        m_el = 0;
      end
      m_busy = (m_pos != m_old);
      if (target_load) m_tgt = target;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("ab",    {a, b},   gray(m_pos));
      check("z",     z,        (m_pos % 1024) == 0);
      check("pos",   pos,      m_pos);
      check("busy",  busy,     m_busy);
      check("ab2",   {a2, b2}, gray(m_pos));
      check("z2",    z2,       (m_pos % 4) == 0);
      check("pos2",  pos2,     m_pos);
      check("busy2", busy2,    m_busy);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [15:0] t);
    target = t; target_load = 1'b1;
    tick(1);
    target_load = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input int maxc, input string nm);
    int k = 0;
    tick(1);
    while (busy && k < maxc) begin
      tick(1);
      k++;
    end
    check(nm, busy, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; target = '0; target_load = 1'b0; period = '0;
    tick(3);
    check("rst_ab", {a, b}, 2'b00);
    check("rst_z", z, 1'b1);
    check("rst_pos", pos, 16'h0000);
    check("rst_busy", busy, 1'b0);

    // Enabled with no load: nothing moves.
    rst_n = 1'b1; enable = 1'b1; period = 16'd4;
    tick(100);
    check("idle_pos", pos, 16'h0000);
    check("idle_ab", {a, b}, 2'b00);

    // period 4, target 3: steps at n+4, n+8, n+12.
    load(16'd3);
    tick(3);
    check("p4_wait_pos", pos, 16'd0);
    tick(1);
    check("p4_s1_pos", pos, 16'd1);
    check("p4_s1_ab", {a, b}, 2'b01);
    tick(4);
    check("p4_s2_pos", pos, 16'd2);
    check("p4_s2_ab", {a, b}, 2'b11);
    check("p4_s2_busy", busy, 1'b1);
    tick(4);
    check("p4_s3_pos", pos, 16'd3);
    check("p4_s3_ab", {a, b}, 2'b10);
    check("p4_s3_busy", busy, 1'b0);

    // Backward wrap through zero.
    do_reset();
    period = 16'd1;
    load(16'hFFFE);
    tick(1);
    check("wrap_pos1", pos, 16'hFFFF);
    check("wrap_ab1", {a, b}, 2'b10);
    tick(1);
    check("wrap_pos2", pos, 16'hFFFE);
    check("wrap_ab2", {a, b}, 2'b11);
    tick(1);
    check("wrap_busy", busy, 1'b0);

    // Index pulses with CPR_LOG2=2 on the way to 9.
    do_reset();
    period = 16'd1;
    load(16'd9);
    for (int k = 1; k <= 9; k++) begin
      tick(1);
      check("idx_pos", pos2, k);
      check("idx_z2", z2, (k == 4 || k == 8));
    end

    // Mid-motion reversal.
    do_reset();
    period = 16'd2;
    load(16'd10);
    tick(10);
    check("rev_pos5", pos, 16'd5);
    load(16'd2);
    check("rev_hold", pos, 16'd5);
    tick(1);
    check("rev_pos4", pos, 16'd4);
    check("rev_ab4", {a, b}, 2'b00);
    wait_idle(50, "rev_settle");
    check("rev_final", pos, 16'd2);

    // Enable freeze and resume, then reset mid-motion.
    do_reset();
    period = 16'd4;
    load(16'd8);
    tick(12);
    check("en_pos3", pos, 16'd3);
    enable = 1'b0;
    tick(20);
    check("en_hold_pos", pos, 16'd3);
    check("en_hold_ab", {a, b}, 2'b10);
    enable = 1'b1;
    tick(3);
    check("en_resume_wait", pos, 16'd3);
    tick(1);
    check("en_resume_pos", pos, 16'd4);
    tick(2);
    rst_n = 1'b0;
    tick(1);
    check("mrst_pos", pos, 16'd0);
    check("mrst_ab", {a, b}, 2'b00);
    check("mrst_z", z, 1'b1);
    check("mrst_busy", busy, 1'b0);
    rst_n = 1'b1;

    // Live period change, period 0 as 1, load coinciding with a step.
    period = 16'd8;
    load(16'd100);
    tick(6);
    period = 16'd3;
    tick(1);
    check("per_low_pos", pos, 16'd1);
    period = 16'd0;
    tick(3);
    check("per0_pos", pos, 16'd4);
    load(16'd0);
    check("simul_pos", pos, 16'd5);
    tick(1);
    check("simul_back", pos, 16'd4);

    // Half-range difference goes backward.
    do_reset();
    period = 16'd1;
    load(16'h8000);
    tick(1);
    check("half_pos", pos, 16'hFFFF);
    do_reset();
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
